// File: rtl/muldiv_unit_if.sv
// Request/response bundle for muldiv_unit: operand handshake in, result handshake out.
interface muldiv_unit_if #(parameter int XLEN = 32);
   logic            in_valid;
   logic            in_ready;
   logic [2:0]      op;
   logic [XLEN-1:0] op1;
   logic [XLEN-1:0] op2;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;
   logic            Z;
   logic            N;

   modport master (output in_valid, op, op1, op2, out_ready,
                   input  in_ready, out_valid, result, Z, N);
   modport slave  (input  in_valid, op, op1, op2, out_ready,
                   output in_ready, out_valid, result, Z, N);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide (shift-add multiply, restoring divide).
// Optional MULDIV_FAST_MUL_EN: multiplies use a single-cycle combinational multiplier.
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   muldiv_unit_if.slave bus
);
   localparam int CW = $clog2(XLEN + 1);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t              state;
   logic [2:0]          op_q;
   logic                neg_q;
   logic [CW-1:0]       cnt;
   logic [2*XLEN-1:0]   acc;
   logic [XLEN-1:0]     opnd;
   logic [XLEN-1:0]     result_q;
   logic                z_q, n_q;

   logic                s1, s2, neg_in, is_div, div_zero, div_ovf;
   logic [XLEN-1:0]     mag1, mag2, special_res, fix_res;
   logic [XLEN:0]       mul_sum, div_diff;
   logic [2*XLEN-1:0]   mul_next, div_next;

   // Sign correction and half/quotient/remainder selection shared by all result paths.
   function automatic logic [XLEN-1:0] finish(input logic [2:0] o, input logic ng,
                                              input logic [2*XLEN-1:0] a);
      logic [2*XLEN-1:0] p;
      logic [XLEN-1:0]   v;
      p = ng ? -a : a;
      v = '0;
      if (!o[2]) begin
         v = (o[1:0] == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
      end else begin
         v = o[1] ? a[2*XLEN-1:XLEN] : a[XLEN-1:0];
         if (ng) v = -v;
      end
      return v;
   endfunction

   assign is_div   = bus.op[2];
   assign s1       = (bus.op == 3'b001 || bus.op == 3'b010 || bus.op == 3'b100 ||
                      bus.op == 3'b110) && bus.op1[XLEN-1];
   assign s2       = (bus.op == 3'b001 || bus.op == 3'b100 || bus.op == 3'b110) &&
                     bus.op2[XLEN-1];
   assign mag1     = s1 ? -bus.op1 : bus.op1;
   assign mag2     = s2 ? -bus.op2 : bus.op2;
   // Remainder takes the dividend's sign; product and quotient the xor of both.
   assign neg_in   = (bus.op == 3'b110) ? s1 : (s1 ^ s2);
   assign div_zero = is_div && (bus.op2 == '0);
   assign div_ovf  = (bus.op == 3'b100 || bus.op == 3'b110) &&
                     (bus.op1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.op2 == '1);
   assign special_res = div_zero ? (bus.op[1] ? bus.op1 : '1)
                                 : (bus.op[1] ? '0 : bus.op1);

   // Multiply: multiplier sits in the low half and shifts out as the product shifts in.
   assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
   assign mul_next = {mul_sum, acc[XLEN-1:1]};
   // Divide: high half is the partial remainder, low half dividend bits becoming quotient.
   assign div_diff = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd};
   assign div_next = div_diff[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                    : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
   assign fix_res  = finish(op_q, neg_q, acc);

`ifdef MULDIV_FAST_MUL_EN
   logic [2*XLEN-1:0] fast_prod;
   logic [XLEN-1:0]   fast_res;
   assign fast_prod = (2*XLEN)'(mag1) * (2*XLEN)'(mag2);
   assign fast_res  = finish(bus.op, neg_in, fast_prod);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         op_q     <= '0;
         neg_q    <= 1'b0;
         cnt      <= '0;
         acc      <= '0;
         opnd     <= '0;
         result_q <= '0;
         z_q      <= 1'b0;
         n_q      <= 1'b0;
      end else if (flush) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: if (bus.in_valid) begin
               op_q  <= bus.op;
               neg_q <= neg_in;
               if (div_zero || div_ovf) begin
                  result_q <= special_res;
                  z_q      <= (special_res == '0);
                  n_q      <= special_res[XLEN-1];
                  state    <= DONE;
               end
`ifdef MULDIV_FAST_MUL_EN
               else if (!is_div) begin
                  result_q <= fast_res;
                  z_q      <= (fast_res == '0);
                  n_q      <= fast_res[XLEN-1];
                  state    <= DONE;
               end
`endif
               else begin
                  cnt   <= CW'(XLEN);
                  opnd  <= is_div ? mag2 : mag1;
                  acc   <= {{XLEN{1'b0}}, (is_div ? mag1 : mag2)};
                  state <= CALC;
               end
            end
            CALC: begin
               acc <= op_q[2] ? div_next : mul_next;
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) state <= FIX;
            end
            FIX: begin
               result_q <= fix_res;
               z_q      <= (fix_res == '0);
               n_q      <= fix_res[XLEN-1];
               state    <= DONE;
            end
            DONE: if (bus.out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.result    = result_q;
   assign bus.Z         = z_q;
   assign bus.N         = n_q;
endmodule
